// File: rtl/bus_arbiter.sv
// Two-master system bus arbiter: round-robin grant, latched one-hot slave select,
// and forced release of a master that holds the bus too long.
module bus_arbiter #(
  parameter int unsigned          SLAVE_LEN = 2,
  parameter int unsigned          SLAVE_NUM = 3,
  parameter int unsigned          TOUT_LEN  = 12,
  parameter logic [TOUT_LEN-1:0]  TIMEOUT   = 12'hFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 breq1_i,
  input  logic                 breq2_i,
  input  logic [SLAVE_LEN-1:0] bslave1_i,
  input  logic [SLAVE_LEN-1:0] bslave2_i,
  input  logic [SLAVE_NUM-1:0] slave_ready_i,
  output logic                 bgrant1_o,
  output logic                 bgrant2_o,
  output logic                 bus_busy_o,
  output logic                 msel_o,
  output logic [SLAVE_NUM-1:0] ssel_o,
  output logic                 req_err_o,
  output logic                 timeout_err_o
);

  localparam logic [SLAVE_LEN:0]  MAX_ID   = (SLAVE_LEN+1)'(SLAVE_NUM);
  localparam logic [TOUT_LEN-1:0] CNT_LAST = TIMEOUT - TOUT_LEN'(1);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, RELEASE} state_e;

  state_e                 state_q, state_d;
  logic [TOUT_LEN-1:0]    cnt_q, cnt_d;
  logic                   last2_q, last2_d;
  logic                   lock1_q, lock1_d, lock2_q, lock2_d;
  logic                   bgrant1_q, bgrant1_d, bgrant2_q, bgrant2_d;
  logic                   bus_busy_q, bus_busy_d;
  logic                   msel_q, msel_d;
  logic [SLAVE_NUM-1:0]   ssel_q, ssel_d;
  logic                   req_err_q, req_err_d;
  logic                   tout_q, tout_d;
  logic                   elig1_c, elig2_c;

  function automatic logic id_valid(input logic [SLAVE_LEN-1:0] id);
    return (id != '0) && ({1'b0, id} <= MAX_ID);
  endfunction

  function automatic logic [SLAVE_NUM-1:0] id_onehot(input logic [SLAVE_LEN-1:0] id);
    logic [SLAVE_NUM-1:0] oh;
    oh = '0;
    for (int k = 0; k < int'(SLAVE_NUM); k++) oh[k] = (id == SLAVE_LEN'(k + 1));
    return oh;
  endfunction

  // A master may only be granted toward a valid, idle slave while not locked out.
  assign elig1_c = breq1_i && id_valid(bslave1_i) && |(id_onehot(bslave1_i) & slave_ready_i) && !lock1_q;
  assign elig2_c = breq2_i && id_valid(bslave2_i) && |(id_onehot(bslave2_i) & slave_ready_i) && !lock2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last2_d   = last2_q;
    lock1_d   = lock1_q && breq1_i;
    lock2_d   = lock2_q && breq2_i;
    bgrant1_d = bgrant1_q;
    bgrant2_d = bgrant2_q;
    msel_d    = msel_q;
    ssel_d    = ssel_q;
    req_err_d = 1'b0;
    tout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        req_err_d = (breq1_i && !id_valid(bslave1_i)) || (breq2_i && !id_valid(bslave2_i));
        // On a tie the master that did not win last time goes first.
        if (elig1_c && (!elig2_c || last2_q)) begin
          state_d   = GRANT1;
          bgrant1_d = 1'b1;
          msel_d    = 1'b0;
          ssel_d    = id_onehot(bslave1_i);
          cnt_d     = '0;
          last2_d   = 1'b0;
        end else if (elig2_c) begin
          state_d   = GRANT2;
          bgrant2_d = 1'b1;
          msel_d    = 1'b1;
          ssel_d    = id_onehot(bslave2_i);
          cnt_d     = '0;
          last2_d   = 1'b1;
        end
      end
      GRANT1, GRANT2: begin
        if (!(state_q == GRANT1 ? breq1_i : breq2_i)) begin
          state_d   = RELEASE;
          bgrant1_d = 1'b0;
          bgrant2_d = 1'b0;
          ssel_d    = '0;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + TOUT_LEN'(1);
        end else begin
          state_d   = RELEASE;
          bgrant1_d = 1'b0;
          bgrant2_d = 1'b0;
          ssel_d    = '0;
          tout_d    = 1'b1;
          if (state_q == GRANT1) lock1_d = 1'b1;
          else                   lock2_d = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    bus_busy_d = bgrant1_d || bgrant2_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last2_q    <= 1'b1;
      lock1_q    <= 1'b0;
      lock2_q    <= 1'b0;
      bgrant1_q  <= 1'b0;
      bgrant2_q  <= 1'b0;
      bus_busy_q <= 1'b0;
      msel_q     <= 1'b0;
      ssel_q     <= '0;
      req_err_q  <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last2_q    <= last2_d;
      lock1_q    <= lock1_d;
      lock2_q    <= lock2_d;
      bgrant1_q  <= bgrant1_d;
      bgrant2_q  <= bgrant2_d;
      bus_busy_q <= bus_busy_d;
      msel_q     <= msel_d;
      ssel_q     <= ssel_d;
      req_err_q  <= req_err_d;
      tout_q     <= tout_d;
    end
  end

  assign bgrant1_o     = bgrant1_q;
  assign bgrant2_o     = bgrant2_q;
  assign bus_busy_o    = bus_busy_q;
  assign msel_o        = msel_q;
  assign ssel_o        = ssel_q;
  assign req_err_o     = req_err_q;
  assign timeout_err_o = tout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: fixed vector table, directed corner sequences, and
// randomized traffic checked every cycle against a transaction-level model.
module tb_bus_arbiter;

  localparam int unsigned SN   = 3;
  localparam int          TOUT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          breq1, breq2;
  logic [1:0]    bslave1, bslave2;
  logic [SN-1:0] slave_ready;
  logic          bgrant1_o, bgrant2_o, bus_busy_o, msel_o, req_err_o, timeout_err_o;
  logic [SN-1:0] ssel_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .SLAVE_LEN(2), .SLAVE_NUM(SN), .TOUT_LEN(12), .TIMEOUT(12'd8)
  ) dut (
    .clk(clk), .reset(reset),
    .breq1_i(breq1), .breq2_i(breq2),
    .bslave1_i(bslave1), .bslave2_i(bslave2),
    .slave_ready_i(slave_ready),
    .bgrant1_o(bgrant1_o), .bgrant2_o(bgrant2_o), .bus_busy_o(bus_busy_o),
    .msel_o(msel_o), .ssel_o(ssel_o),
    .req_err_o(req_err_o), .timeout_err_o(timeout_err_o)
  );

  // Reference model: who owns the bus, for how many cycles, and who is locked out.
  int            m_owner;
  int            m_held;
  int            m_last;
  bit            m_turn;
  bit            m_lock [1:2];
  logic [SN-1:0] m_ssel;
  bit            m_msel, m_err, m_tout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_held = 0; m_last = 2; m_turn = 0;
    m_lock[1] = 0; m_lock[2] = 0;
    m_ssel = '0; m_msel = 0; m_err = 0; m_tout = 0;
  endtask

  function automatic bit id_ok(input int id);
    return id >= 1 && id <= int'(SN);
  endfunction

  task automatic model_step();
    bit rq [1:2];
    int id [1:2];
    bit el [1:2];
    bit nl [1:2];
    int w;
    rq[1] = breq1; rq[2] = breq2;
    id[1] = int'(bslave1); id[2] = int'(bslave2);
    m_err = 0; m_tout = 0;
    for (int m = 1; m <= 2; m++) nl[m] = m_lock[m] && rq[m];
    if (m_turn) begin
      m_turn = 0;
    end else if (m_owner != 0) begin
      w = m_owner;
      if (!rq[w]) begin
        m_owner = 0; m_turn = 1; m_ssel = '0;
      end else if (m_held == TOUT) begin
        m_owner = 0; m_turn = 1; m_ssel = '0; m_tout = 1; nl[w] = 1;
      end else begin
        m_held++;
      end
    end else begin
      for (int m = 1; m <= 2; m++) begin
        el[m] = 0;
        if (rq[m] && !id_ok(id[m])) m_err = 1;
        if (rq[m] && id_ok(id[m]) && !m_lock[m]) begin
          if (slave_ready[id[m]-1]) el[m] = 1;
        end
      end
      w = 0;
      if (el[1] && el[2]) w = 3 - m_last;
      else if (el[1])     w = 1;
      else if (el[2])     w = 2;
      if (w != 0) begin
        m_owner = w; m_held = 1; m_last = w;
        m_ssel = SN'(1) << (id[w] - 1);
        m_msel = (w == 2);
      end
    end
    m_lock[1] = nl[1]; m_lock[2] = nl[2];
  endtask

  task automatic model_check();
    logic g1, g2;
    g1 = (m_owner == 1);
    g2 = (m_owner == 2);
    chk("model_out",
        32'({bgrant1_o, bgrant2_o, bus_busy_o, ssel_o, req_err_o, timeout_err_o}),
        32'({g1, g2, g1 | g2, m_ssel, m_err, m_tout}));
    if (m_owner != 0) chk("model_msel", 32'(msel_o), 32'(m_msel));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    breq1 = 0; breq2 = 0; bslave1 = 0; bslave2 = 0; slave_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_out",
        32'({bgrant1_o, bgrant2_o, bus_busy_o, msel_o, ssel_o, req_err_o, timeout_err_o}), 32'd0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic b1, b2;
    logic [1:0] s1, s2;
    logic [2:0] rdy;
    logic g1, g2;
    logic [2:0] ssel;
    logic msel, err;
  } vec_t;

  vec_t vt [15];

  initial begin
    int t, hi, pulses;
    logic [1:0] who;

    vt[0]  = '{1'b1, 1'b0, 2'd2, 2'd0, 3'b111, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 2'd2, 2'd0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 2'd2, 2'd0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 2'd2, 2'd0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 2'd2, 2'd3, 3'b011, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 2'd1, 2'd3, 3'b111, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 2'd1, 2'd3, 3'b111, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 2'd1, 2'd3, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 2'd1, 2'd3, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 2'd1, 2'd3, 3'b111, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 2'd3, 2'd3, 3'b111, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 2'd3, 2'd2, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 2'd3, 2'd2, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b1, 2'd3, 2'd2, 3'b111, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b0, 2'd3, 2'd2, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      breq1 = vt[i].b1; breq2 = vt[i].b2;
      bslave1 = vt[i].s1; bslave2 = vt[i].s2; slave_ready = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d", i),
          32'({bgrant1_o, bgrant2_o, bus_busy_o, ssel_o, req_err_o}),
          32'({vt[i].g1, vt[i].g2, vt[i].g1 | vt[i].g2, vt[i].ssel, vt[i].err}));
      if (vt[i].g1 || vt[i].g2) chk($sformatf("vec%0d_msel", i), 32'(msel_o), 32'(vt[i].msel));
    end

    // Both masters contend continuously; each owner steps aside once.
    do_reset();
    breq1 = 1; breq2 = 1; bslave1 = 2'd1; bslave2 = 2'd2; slave_ready = 3'b111;
    for (int r = 0; r < 4; r++) begin
      t = 0;
      do begin tick(); t++; end while (!(bgrant1_o || bgrant2_o) && t < 10);
      who = bgrant2_o ? 2'd2 : (bgrant1_o ? 2'd1 : 2'd0);
      chk($sformatf("rr_order%0d", r), 32'(who), (r % 2 == 0) ? 32'd1 : 32'd2);
      if (who == 2'd1) breq1 = 0; else breq2 = 0;
      tick();
      chk("rr_gap", 32'({bgrant1_o, bgrant2_o, ssel_o}), 32'd0);
      breq1 = 1; breq2 = 1;
    end

    // Master 1 overstays; master 2 gets the bus next; master 1 must drop to re-arm.
    do_reset();
    breq1 = 1; breq2 = 1; bslave1 = 2'd1; bslave2 = 2'd2; slave_ready = 3'b111;
    hi = 0; pulses = 0;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (bgrant1_o) hi++;
      if (timeout_err_o) pulses++;
    end
    chk("tout_hold_cycles", 32'(hi), 32'(TOUT));
    chk("tout_pulses", 32'(pulses), 32'd1);
    chk("tout_next_owner", 32'(bgrant2_o), 32'd1);
    breq2 = 0;
    tick(); tick(); tick();
    chk("tout_locked", 32'(bgrant1_o), 32'd0);
    breq1 = 0;
    tick();
    breq1 = 1;
    tick();
    chk("tout_unlocked", 32'(bgrant1_o), 32'd1);

    // Asynchronous reset while master 2 owns the bus.
    do_reset();
    breq2 = 1; bslave2 = 2'd3; slave_ready = 3'b111;
    tick();
    chk("pre_reset_g2", 32'(bgrant2_o), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_out",
        32'({bgrant1_o, bgrant2_o, bus_busy_o, ssel_o, timeout_err_o}), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    breq1 = 1; bslave1 = 2'd2;
    tick();
    chk("post_reset_tie", 32'({bgrant1_o, bgrant2_o}), 32'b10);

    // Randomized traffic with long-held requests and flickering slave readiness.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) breq1 = ~breq1;
      if ($urandom_range(5) == 0) breq2 = ~breq2;
      if ($urandom_range(7) == 0) bslave1 = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) bslave2 = 2'($urandom_range(3));
      slave_ready = ~(3'($urandom_range(7)) & 3'($urandom_range(7)) & 3'($urandom_range(7)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
